// File: rtl/uart_rx_deframer_if.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------+
// | uart_rx_deframer_if : received-word valid/ready holding interface   |
// | Revision 1.0                                                        |
// +---------------------------------------------------------------------+
interface uart_rx_deframer_if #(
   parameter int MAX_DATA_BITS = 9
);
   logic [MAX_DATA_BITS-1:0] rx_data;
   logic                     rx_perr;
   logic                     rx_ferr;
   logic                     rx_ovf;
   logic                     rx_valid;
   logic                     rx_ready;

   modport master (
      output rx_data, rx_perr, rx_ferr, rx_ovf, rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_perr, rx_ferr, rx_ovf, rx_valid,
      output rx_ready
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------+
// | uart_rx_deframer : start/data/parity/stop deframer with holding reg |
// | Optional parity support: define UART_RX_PARITY_EN. Revision 1.0     |
// +---------------------------------------------------------------------+
module uart_rx_deframer #(
   parameter int MAX_DATA_BITS = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bit_stb,
   input  logic                  bit_in,
   input  logic [4:0]            data_bits,
   input  logic                  pen,
   input  logic                  ep,
   output logic                  busy,
   uart_rx_deframer_if.master    rx
);

   localparam logic [4:0] c_max_bits = 5'(MAX_DATA_BITS);
   localparam logic [4:0] c_min_bits = 5'd5;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0, S_DATA = 2'd1, S_STOP = 2'd3
   } state_t;
`endif

   state_t                   state_q, state_d;
   logic [MAX_DATA_BITS-1:0] sr_q, sr_d;
   logic [4:0]               cnt_q, cnt_d;
   logic [4:0]               n_q, n_d;
   logic [4:0]               w_n_clamped;
   logic [4:0]               w_cnt_inc;
   logic [MAX_DATA_BITS-1:0] w_word;
   logic                     w_done;
   logic                     perr_q, perr_d;

   logic [MAX_DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                     rx_perr_q, rx_perr_d;
   logic                     rx_ferr_q, rx_ferr_d;
   logic                     rx_ovf_q, rx_ovf_d;
   logic                     rx_valid_q, rx_valid_d;

`ifdef UART_RX_PARITY_EN
   logic                     pen_q, pen_d;
   logic                     ep_q, ep_d;
`else
   logic                     w_unused_cfg;
   assign w_unused_cfg = pen ^ ep;
`endif

   always_comb begin
      w_n_clamped = data_bits;
      if (data_bits < c_min_bits)      w_n_clamped = c_min_bits;
      else if (data_bits > c_max_bits) w_n_clamped = c_max_bits;
   end

   assign w_cnt_inc = cnt_q + 5'd1;
   // Data sits in the top n bits after shifting; move it down to bit 0.
   assign w_word    = sr_q >> (c_max_bits - n_q);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      perr_d  = perr_q;
      w_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pen_d   = pen_q;
      ep_d    = ep_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bit_stb && !bit_in) begin
               state_d = S_DATA;
               sr_d    = '0;
               cnt_d   = '0;
               n_d     = w_n_clamped;
               perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
               pen_d   = pen;
               ep_d    = ep;
`endif
            end
         end
         S_DATA: begin
            if (bit_stb) begin
               sr_d  = {bit_in, sr_q[MAX_DATA_BITS-1:1]};
               cnt_d = w_cnt_inc;
               if (w_cnt_inc == n_q) begin
`ifdef UART_RX_PARITY_EN
                  state_d = pen_q ? S_PARITY : S_STOP;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_stb) begin
               // Unused low bits of sr are zero, so ^sr equals ^data.
               perr_d  = (^sr_q) ^ bit_in ^ ~ep_q;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_stb) begin
               w_done  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_ovf_d   = rx_ovf_q;
      rx_valid_d = rx_valid_q;
      if (w_done) begin
         if (!rx_valid_q || rx.rx_ready) begin
            rx_data_d  = w_word;
            rx_perr_d  = perr_q;
            rx_ferr_d  = ~bit_in;
            rx_valid_d = 1'b1;
            rx_ovf_d   = 1'b0;
         end else begin
            rx_ovf_d   = 1'b1;
         end
      end else if (rx_valid_q && rx.rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         n_q        <= c_min_bits;
         perr_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_ovf_q   <= 1'b0;
         rx_valid_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pen_q      <= 1'b0;
         ep_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         perr_q     <= perr_d;
         rx_data_q  <= rx_data_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_ovf_q   <= rx_ovf_d;
         rx_valid_q <= rx_valid_d;
`ifdef UART_RX_PARITY_EN
         pen_q      <= pen_d;
         ep_q       <= ep_d;
`endif
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign rx.rx_data  = rx_data_q;
`ifdef UART_RX_PARITY_EN
   assign rx.rx_perr  = rx_perr_q;
`else
   assign rx.rx_perr  = 1'b0;
`endif
   assign rx.rx_ferr  = rx_ferr_q;
   assign rx.rx_ovf   = rx_ovf_q;
   assign rx.rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------+
// | tb_uart_rx_deframer : randomized frames against a bit-queue model   |
// | Revision 1.0                                                        |
// +---------------------------------------------------------------------+
module tb_uart_rx_deframer;

   localparam int MDB = 9;
`ifdef UART_RX_PARITY_EN
   localparam bit C_PAR = 1'b1;
`else
   localparam bit C_PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_stb = 1'b0;
   logic       bit_in = 1'b1;
   logic [4:0] data_bits = 5'd8;
   logic       pen = 1'b0;
   logic       ep = 1'b0;
   logic       rx_ready = 1'b0;
   logic       busy;

   uart_rx_deframer_if #(.MAX_DATA_BITS(MDB)) rx_if ();
   assign rx_if.rx_ready = rx_ready;

   uart_rx_deframer #(.MAX_DATA_BITS(MDB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_stb   (bit_stb),
      .bit_in    (bit_in),
      .data_bits (data_bits),
      .pen       (pen),
      .ep        (ep),
      .busy      (busy),
      .rx        (rx_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit rand_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_n(input logic [4:0] v);
      if (int'(v) < 5)   return 5;
      if (int'(v) > MDB) return MDB;
      return int'(v);
   endfunction

   // Model: collect every bit after a start bit; the frame ends when
   // n data + optional parity + 1 stop bits have been gathered.
   bit          m_busy, m_valid, m_perr, m_ferr, m_ovf;
   logic [15:0] m_data;
   int          m_n;
   bit          m_pen, m_ep, m_done;
   bit          m_bits[$];
   logic [15:0] f_data;
   bit          f_perr, f_ferr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
         m_data = '0;
         m_bits.delete();
      end else begin
         m_done = 0;
         if (bit_stb) begin
            if (!m_busy) begin
               if (bit_in == 1'b0) begin
                  m_busy = 1;
                  m_n    = clamp_n(data_bits);
                  m_pen  = C_PAR & pen;
                  m_ep   = ep;
                  m_bits.delete();
               end
            end else begin
               m_bits.push_back(bit_in);
               if (m_bits.size() == m_n + int'(m_pen) + 1) begin
                  f_data = '0;
                  for (int i = 0; i < m_n; i++) f_data[i] = m_bits[i];
                  f_perr = m_pen ? ((^f_data) ^ m_bits[m_n] ^ ~m_ep) : 1'b0;
                  f_ferr = ~m_bits[m_bits.size()-1];
                  m_done = 1;
                  m_busy = 0;
               end
            end
         end
         if (m_done) begin
            if (!m_valid || rx_ready) begin
               m_data = f_data; m_perr = f_perr; m_ferr = f_ferr;
               m_valid = 1; m_ovf = 0;
            end else begin
               m_ovf = 1;
            end
         end else if (m_valid && rx_ready) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("rx_valid", 32'(rx_if.rx_valid), 32'(m_valid));
         if (m_valid) begin
            check("rx_data", 32'(rx_if.rx_data), 32'(m_data));
            check("rx_perr", 32'(rx_if.rx_perr), 32'(m_perr));
            check("rx_ferr", 32'(rx_if.rx_ferr), 32'(m_ferr));
            check("rx_ovf",  32'(rx_if.rx_ovf),  32'(m_ovf));
         end
      end
   end

   // Called at a falling edge; returns at a falling edge.
   task automatic send_bit(input logic b, input int gap);
      bit_stb = 1'b1;
      bit_in  = b;
      if (rand_mode) rx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      bit_stb = 1'b0;
      bit_in  = 1'b1;
      repeat (gap) begin
         if (rand_mode) rx_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [15:0] d, input logic [4:0] nb, input logic p_en,
                             input logic e_p, input logic pbit, input logic stop,
                             input int gap, input bit ready_at_stop);
      int n;
      n = clamp_n(nb);
      data_bits = nb; pen = p_en; ep = e_p;
      send_bit(1'b0, gap);
      if (rand_mode) begin
         data_bits = 5'($urandom_range(0, 31));
         pen       = 1'($urandom_range(0, 1));
         ep        = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < n; i++) send_bit(d[i], gap);
      if (p_en) send_bit(pbit, gap);
      if (ready_at_stop) rx_ready = 1'b1;
      send_bit(stop, 0);
      if (ready_at_stop) rx_ready = 1'b0;
   endtask

   task automatic accept();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("accept_drop", 32'(rx_if.rx_valid), 32'd0);
   endtask

   task automatic check_word(input string tag, input logic [15:0] d, input bit pe,
                             input bit fe, input bit ov);
      check({tag, "_valid"}, 32'(rx_if.rx_valid), 32'd1);
      check({tag, "_data"},  32'(rx_if.rx_data),  32'(d));
      check({tag, "_perr"},  32'(rx_if.rx_perr),  32'(pe));
      check({tag, "_ferr"},  32'(rx_if.rx_ferr),  32'(fe));
      check({tag, "_ovf"},   32'(rx_if.rx_ovf),   32'(ov));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},  32'(busy),            32'd0);
      check({tag, "_valid"}, 32'(rx_if.rx_valid),  32'd0);
      check({tag, "_data"},  32'(rx_if.rx_data),   32'd0);
      check({tag, "_perr"},  32'(rx_if.rx_perr),   32'd0);
      check({tag, "_ferr"},  32'(rx_if.rx_ferr),   32'd0);
      check({tag, "_ovf"},   32'(rx_if.rx_ovf),    32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 0,1,0,1,0,0,1,0,1,1 -> 0xA5
      send_frame(16'h00A5, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      check_word("t1", 16'h00A5, 1'b0, 1'b0, 1'b0);
      accept();

      // Without parity support the parity bit is taken as the stop bit.
      send_frame(16'h0041, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      check_word("t2a", 16'h0041, 1'b0, C_PAR ? 1'b0 : 1'b1, 1'b0);
      accept();
      send_frame(16'h0041, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      check_word("t2b", 16'h0041, C_PAR ? 1'b1 : 1'b0, 1'b0, 1'b0);
      accept();
      send_frame(16'h0041, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      check_word("t2c", 16'h0041, 1'b0, 1'b0, 1'b0);
      accept();

      send_frame(16'h0013, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check_word("t3", 16'h0013, 1'b0, 1'b1, 1'b0);
      send_bit(1'b1, 1);
      check("t3_idle_busy", 32'(busy), 32'd0);
      accept();

      send_frame(16'h0011, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      send_frame(16'h0022, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      check_word("t4_ovf", 16'h0011, 1'b0, 1'b0, 1'b1);
      accept();
      send_frame(16'h0033, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      check_word("t4_next", 16'h0033, 1'b0, 1'b0, 1'b0);

      send_frame(16'h0044, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      check("t5_pre_ovf", 32'(rx_if.rx_ovf), 32'd1);
      send_frame(16'h0055, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      check_word("t5_same_cycle", 16'h0055, 1'b0, 1'b0, 1'b0);

      data_bits = 5'd8; pen = 1'b0;
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'(i), 0);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("t6_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(16'h005A, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      check_word("t6_after", 16'h005A, 1'b0, 1'b0, 1'b0);
      accept();

      send_frame(16'h001B, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      check_word("t7_n3", 16'h001B, 1'b0, 1'b0, 1'b0);
      accept();
      send_frame(16'h01A5, 5'd20, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      check_word("t7_n20", 16'h01A5, 1'b0, 1'b0, 1'b0);
      accept();

      rand_mode = 1'b1;
      for (int k = 0; k < 400; k++) begin
         send_frame(16'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) != 0), $urandom_range(0, 2), 1'b0);
         if ($urandom_range(0, 3) == 0) send_bit(1'b1, $urandom_range(0, 2));
      end
      rand_mode = 1'b0;
      rx_ready  = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Parametrised receive deframer for the UART receive path. It accepts one sampled bit per strobe from the receive bit-timing logic and tracks start, data, optional parity and stop bits with a small state machine. It shifts data bits into a right-shifting register and right-justifies the captured word for any data length from 5 to MAX_DATA_BITS. It presents the word with parity, framing and overrun status through a valid/ready holding register.

## Interface
- MAX_DATA_BITS, 9, widest supported data field; legal range 5..16.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_stb  in  1  one-cycle strobe: bit_in is a valid mid-bit sample.
- bit_in  in  1  sampled serial line value.
- data_bits  in  5  configured data length; values below 5 are treated as 5, values above MAX_DATA_BITS as MAX_DATA_BITS.
- pen  in  1  parity enable.
- ep  in  1  even parity when 1, odd when 0.
- rx_data  out  MAX_DATA_BITS  right-justified received word, upper unused bits 0.
- rx_perr  out  1  parity error for the held word.
- rx_ferr  out  1  framing error (stop bit sampled 0) for the held word.
- rx_ovf  out  1  at least one completed frame was dropped while holding this word.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, DATA, PARITY and STOP. Transitions occur only on cycles with bit_stb=1.
- IDLE:
  - bit_in=1 is ignored.
  - bit_in=0 (start bit) goes to DATA.
  - On entry, the block latches the clamped data_bits (n), pen and ep. Configuration changes mid-frame have no effect.
  - On entry, the shift register and bit counter are cleared.
- DATA:
  - Each strobe shifts right: sr <= {bit_in, sr[MAX_DATA_BITS-1:1]}. Bits arrive LSB first.
  - After the n-th data bit, go to PARITY if the latched pen=1, otherwise go to STOP.
- PARITY: the strobe captures the parity bit and goes to STOP. Parity error = (^data) ^ pbit ^ ~ep.
- STOP:
  - The strobe samples the stop bit; ferr = ~bit_in. The frame is then complete and the FSM returns to IDLE.
  - A stop bit of 0 still returns to IDLE. That 0 is not reinterpreted as a new start bit.
- Right-justify rule: data = sr >> (MAX_DATA_BITS - n), zero-filled.
- Frame completion with the holding register empty, or being accepted in the same cycle: load rx_data/rx_perr/rx_ferr, set rx_valid, clear rx_ovf.
- Frame completion with rx_valid=1 and rx_ready=0:
  - The new frame is discarded and the old word is kept.
  - rx_ovf is set (sticky) and clears only when a new word is loaded.
- Accept without a new completion: rx_valid clears. rx_data and the flags retain their values but are don't-care.

## Timing
- Reset values: rx_data=0, rx_perr=0, rx_ferr=0, rx_ovf=0, rx_valid=0, busy=0, FSM in IDLE.
- Reset asserted mid-frame aborts immediately (asynchronous). The first frame after release must begin with a fresh start bit.
- busy rises the cycle after the start-bit strobe and falls the cycle after the stop-bit strobe.
- rx_valid and the new rx_data are registered and appear the cycle after the stop-bit strobe (latency 1 clk).
- rx_valid stays high until the clock edge on which rx_valid && rx_ready.
- bit_stb on consecutive cycles must be supported (one state step per strobe).

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state, pen/ep latching and rx_perr logic are built as described.
- UART_RX_PARITY_EN undefined:
  - The PARITY state is removed, pen and ep are ignored, and DATA always proceeds to STOP.
  - rx_perr is tied 0.
  - A frame sent with a parity bit has that bit sampled as its stop bit.

## Test plan
- MAX_DATA_BITS=9, n=8, pen=0; serial 0,1,0,1,0,0,1,0,1,1 -> rx_data=0x0A5, perr=0, ferr=0, rx_valid high one cycle after the last strobe.
- n=7, pen=1, ep=1; data 0x41, parity bit 0, then stop 1 -> rx_data=0x041, perr=0. Repeat with parity bit 1 -> perr=1. Repeat with ep=0 and parity bit 1 -> perr=0.
- n=5, pen=0; data 0x13, stop bit 0 -> rx_data=0x013, ferr=1. A following idle 1 does not start a frame.
- rx_ready=0; two complete frames 0x11 then 0x22 -> rx_data remains 0x011, rx_ovf=1. Assert rx_ready -> rx_valid drops. The next frame 0x33 loads with rx_ovf=0.
- rx_ready tied 1 with a frame completing in the accept cycle -> new word loads, rx_valid stays 1, rx_ovf=0.
- Assert rst_n=0 after 4 data bits -> all outputs at reset values immediately. After release, a clean frame 0x5A is received correctly. Also check that data_bits=3 behaves as 5 and data_bits=20 behaves as 9.
